// File: rtl/cur_mb_fetch.sv
// cur_mb_fetch: reads one 16x16 current-frame MB as 32 two-word beats
// over a dual-port memory and streams them through a 2-entry FIFO.
module cur_mb_fetch #(
    parameter int MB_COLS = 240,
    parameter int MB_ROWS = 135,
    parameter int ADDR_W  = 23,
    parameter int ROW_OFS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        mb_x,
    input  logic [7:0]        mb_y,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata1,
    input  logic [31:0]       mem_rdata2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_row,
    output logic [1:0]        out_word,
    output logic [31:0]       out_data_a,
    output logic [31:0]       out_data_b
);

    // Port B sits this many MB rows below port A; skip those rows on A.
    localparam logic [3:0] ROW_SKIP = 4'(ROW_OFS / 16);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_k;
    logic [ADDR_W-1:0] r_base;
    logic              r_err;

    logic              r_inf;
    logic [3:0]        r_inf_row;
    logic [1:0]        r_inf_word;

    logic [3:0]        r_f_row  [2];
    logic [1:0]        r_f_word [2];
    logic [31:0]       r_f_da   [2];
    logic [31:0]       r_f_db   [2];
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_cnt;

    logic              w_req_ok;
    logic              w_accept;
    logic [ADDR_W-1:0] w_base;
    logic [3:0]        w_s;
    logic [1:0]        w_w;
    logic [3:0]        w_row;
    logic [7:0]        w_ofs;
    logic [ADDR_W-1:0] w_addr;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;

    assign w_req_ok = (int'(mb_x) < MB_COLS) && (int'(mb_y) < MB_ROWS);
    assign w_accept = (r_state == S_IDLE) && start && w_req_ok;
    assign w_base   = (ADDR_W'(mb_y) * ADDR_W'(MB_COLS) + ADDR_W'(mb_x)) << 8;

    assign w_s    = {2'b00, r_k[4:2]};
    assign w_w    = r_k[1:0];
    assign w_row  = (w_s < ROW_SKIP) ? w_s : w_s + ROW_SKIP;
    assign w_ofs  = {w_row, w_w, 2'b00};
    assign w_addr = r_base + ADDR_W'(w_ofs);

    // Credit: FIFO entries plus the read in flight, less this cycle's pop.
    assign w_pop   = (r_cnt != 2'd0) && out_ready;
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inf} - {2'b00, w_pop};
    assign w_issue = (r_state == S_FETCH) && (w_occ < 3'd2);

    // Next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                mem_rd_en = w_issue;
                if (w_issue && (r_k == 5'd31)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_pop && (r_cnt == 2'd1) && !r_inf) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, beat counter and range-error pulse.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_base <= '0;
            r_k    <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && start && !w_req_ok;
            if (w_accept) begin
                r_base <= w_base;
                r_k    <= '0;
            end else if (w_issue) begin
                r_k <= r_k + 5'd1;
            end
        end
    end

    // Tag of the read whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_inf      <= 1'b0;
            r_inf_row  <= '0;
            r_inf_word <= '0;
        end else begin
            r_inf      <= w_issue;
            r_inf_row  <= w_row;
            r_inf_word <= w_w;
        end
    end

    // Two-entry output FIFO fed by returning read data.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_f_row[0]  <= '0;
            r_f_row[1]  <= '0;
            r_f_word[0] <= '0;
            r_f_word[1] <= '0;
            r_f_da[0]   <= '0;
            r_f_da[1]   <= '0;
            r_f_db[0]   <= '0;
            r_f_db[1]   <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (r_inf) begin
                r_f_row[r_wp]  <= r_inf_row;
                r_f_word[r_wp] <= r_inf_word;
                r_f_da[r_wp]   <= mem_rdata1;
                r_f_db[r_wp]   <= mem_rdata2;
                r_wp           <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, r_inf} - {1'b0, w_pop};
        end
    end

    assign err        = r_err;
    assign mem_addr   = mem_rd_en ? w_addr : '0;
    assign out_valid  = (r_cnt != 2'd0);
    assign out_row    = r_f_row[r_rp];
    assign out_word   = r_f_word[r_rp];
    assign out_data_a = r_f_da[r_rp];
    assign out_data_b = r_f_db[r_rp];

endmodule

// File: tb/tb_cur_mb_fetch.sv
// tb_cur_mb_fetch: directed stimulus with a queue scoreboard for
// addresses and beats, plus timing, flow-control and reset checks.
module tb_cur_mb_fetch;

    localparam int AW      = 23;
    localparam int ROW     = 64;
    localparam int FRAME_B = 8294400;

    typedef struct {
        logic [3:0]  row;
        logic [1:0]  word;
        logic [31:0] da;
        logic [31:0] db;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    mb_x = '0;
    logic [7:0]    mb_y = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata1 = '0;
    logic [31:0]   mem_rdata2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    out_row;
    logic [1:0]    out_word;
    logic [31:0]   out_data_a;
    logic [31:0]   out_data_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int nreads = 0;
    int npops = 0;
    int ndone = 0;
    int done_cyc = -1;
    int first_rd = -1;
    int last_rd = -1;
    int first_v = -1;
    int last_v = -1;
    int outst = 0;
    bit rnd_mode = 1'b0;

    int unsigned aq[$];
    beat_t       bq[$];

    cur_mb_fetch #(
        .MB_COLS(240),
        .MB_ROWS(135),
        .ADDR_W (AW),
        .ROW_OFS(ROW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mb_x      (mb_x),
        .mb_y      (mb_y),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata1(mem_rdata1),
        .mem_rdata2(mem_rdata2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_word  (out_word),
        .out_data_a(out_data_a),
        .out_data_b(out_data_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame memory: byte i holds i mod 256, leftmost byte in the MSB.
    function automatic logic [31:0] mword(int unsigned a);
        return {8'(a), 8'(a + 1), 8'(a + 2), 8'(a + 3)};
    endfunction

    // Dual-port memory model with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata1 <= mword(int'(mem_addr));
            mem_rdata2 <= mword(int'(mem_addr) + ROW);
        end
    end

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_mb(int mx, int my);
        int unsigned base;
        base = (my * 240 + mx) * 256;
        for (int k = 0; k < 32; k++) begin
            int s;
            int r;
            int w;
            int unsigned a;
            beat_t b;
            s = k / 4;
            w = k % 4;
            r = (s < 4) ? s : s + 4;
            a = base + r * 16 + w * 4;
            aq.push_back(a);
            b.row  = 4'(r);
            b.word = 2'(w);
            b.da   = mword(a);
            b.db   = mword(a + ROW);
            bq.push_back(b);
        end
    endtask

    task automatic pulse_start(int mx, int my);
        @(posedge clk);
        #1;
        mb_x  = 8'(mx);
        mb_y  = 8'(my);
        start = 1'b1;
        t0 = cyc;
        first_rd = -1;
        first_v = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int n_before, string nm);
        int b;
        b = 0;
        while (ndone == n_before && b < 3000) begin
            @(posedge clk);
            b++;
        end
        chk(nm, longint'(ndone > n_before), 1);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_rd_en"}, mem_rd_en, 0);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_addr"}, mem_addr, 0);
        chk({nm, "_row_word"}, {out_row, out_word}, 0);
        chk({nm, "_data"}, {out_data_a, out_data_b}, 0);
    endtask

    // Downstream ready: constant high, or a fixed stall pattern.
    initial begin
        logic [31:0] pat;
        int pidx;
        pat = 32'hC271_A386;
        pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                out_ready = pat[pidx];
                pidx = (pidx + 1) % 32;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops expected reads/beats and checks flow control.
    initial begin
        logic        prev_stall;
        logic [3:0]  p_row;
        logic [1:0]  p_word;
        logic [31:0] p_da;
        logic [31:0] p_db;
        beat_t       e;
        prev_stall = 1'b0;
        p_row = '0;
        p_word = '0;
        p_da = '0;
        p_db = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                prev_stall = 1'b0;
                outst = 0;
            end else begin
                if (mem_rd_en) begin
                    chk("addr_in_frame",
                        longint'(int'(mem_addr) + ROW + 3 < FRAME_B), 1);
                    if (aq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_read addr=%0d", mem_addr);
                    end else begin
                        chk("mem_addr", mem_addr, aq.pop_front());
                    end
                    nreads++;
                    outst++;
                    if (first_rd < 0) first_rd = cyc;
                    last_rd = cyc;
                end
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_row", {out_row, out_word}, {p_row, p_word});
                    chk("stall_da", out_data_a, p_da);
                    chk("stall_db", out_data_b, p_db);
                end
                if (out_valid) begin
                    if (first_v < 0) first_v = cyc;
                    last_v = cyc;
                end
                if (out_valid && out_ready) begin
                    if (bq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat row=%0d word=%0d",
                                 out_row, out_word);
                    end else begin
                        e = bq.pop_front();
                        chk("beat_row", out_row, e.row);
                        chk("beat_word", out_word, e.word);
                        chk("beat_da", out_data_a, e.da);
                        chk("beat_db", out_data_b, e.db);
                    end
                    npops++;
                    outst--;
                end
                chk("buffered_le_2", longint'(outst <= 2), 1);
                if (done) begin
                    ndone++;
                    done_cyc = cyc;
                    chk("done_not_busy", busy, 0);
                end
                prev_stall = out_valid && !out_ready;
                p_row = out_row;
                p_word = out_word;
                p_da = out_data_a;
                p_db = out_data_b;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    // Directed test sequence.
    initial begin
        int nd;
        int nr;
        int np;
        int b;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // MB (0,0), ready high: exact latency and first beat data.
        nd = ndone;
        nr = nreads;
        push_mb(0, 0);
        pulse_start(0, 0);
        @(negedge clk);
        chk("t1_busy_c1", busy, 1);
        wait_done(nd, "t1_done_seen");
        chk("t1_first_rd", first_rd - t0, 1);
        chk("t1_last_rd", last_rd - t0, 32);
        chk("t1_first_valid", first_v - t0, 3);
        chk("t1_last_valid", last_v - t0, 34);
        chk("t1_done_cycle", done_cyc - t0, 35);
        chk("t1_nreads", nreads - nr, 32);
        chk("t1_queue_empty", aq.size() + bq.size(), 0);

        // Last MB of the frame: no wrap, no out-of-frame read.
        nd = ndone;
        push_mb(239, 134);
        pulse_start(239, 134);
        wait_done(nd, "t2_done_seen");
        chk("t2_queue_empty", aq.size() + bq.size(), 0);

        // Out-of-range requests: err pulse only.
        nr = nreads;
        pulse_start(240, 0);
        @(negedge clk);
        chk("t3x_err", err, 1);
        chk("t3x_quiet", {busy, mem_rd_en, out_valid}, 0);
        @(negedge clk);
        chk("t3x_err_pulse", err, 0);
        pulse_start(0, 135);
        @(negedge clk);
        chk("t3y_err", err, 1);
        chk("t3y_quiet", {busy, mem_rd_en, out_valid}, 0);
        @(negedge clk);
        chk("t3y_err_pulse", err, 0);
        chk("t3_no_reads", nreads - nr, 0);

        // Stalling downstream on MB (5,7).
        nd = ndone;
        push_mb(5, 7);
        rnd_mode = 1'b1;
        pulse_start(5, 7);
        wait_done(nd, "t4_done_seen");
        rnd_mode = 1'b0;
        repeat (4) @(posedge clk);
        chk("t4_one_done", ndone - nd, 1);
        chk("t4_queue_empty", aq.size() + bq.size(), 0);

        // Start while busy is ignored.
        nd = ndone;
        nr = nreads;
        push_mb(2, 3);
        pulse_start(2, 3);
        repeat (5) @(posedge clk);
        pulse_start(4, 4);
        wait_done(nd, "t5_done_seen");
        repeat (6) @(posedge clk);
        chk("t5_one_done", ndone - nd, 1);
        chk("t5_nreads", nreads - nr, 32);
        chk("t5_queue_empty", aq.size() + bq.size(), 0);
        nd = ndone;
        push_mb(0, 1);
        pulse_start(0, 1);
        wait_done(nd, "t5_next_done");
        chk("t5_next_empty", aq.size() + bq.size(), 0);

        // Reset at beat 10, then a fresh fetch of MB (1,0).
        np = npops;
        push_mb(3, 2);
        pulse_start(3, 2);
        b = 0;
        while (npops - np < 10 && b < 200) begin
            @(posedge clk);
            b++;
        end
        chk("t6_reach_beat10", longint'(npops - np >= 10), 1);
        #2;
        rst_n = 1'b1;
        aq.delete();
        bq.delete();
        @(posedge clk);
        @(negedge clk);
        chk_zero("t6_in_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        nd = ndone;
        push_mb(1, 0);
        pulse_start(1, 0);
        wait_done(nd, "t6_done_seen");
        chk("t6_queue_empty", aq.size() + bq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
